// File: rtl/pcm_sample_fifo.sv
// Stereo PCM elastic buffer feeding the I2S serializer.
// Absorbs producer rate jitter, primes to half full before playback,
// conceals underflow by repeating the last frame, and applies an optional
// mono mix plus power-of-two attenuation in a two-stage output pipeline.
module pcm_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk_50MHz,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_l,
  input  logic [WIDTH-1:0]         in_r,
  output logic                     in_ready,
  input  logic                     out_req,
  input  logic                     mono,
  input  logic [2:0]               vol_shift,
  input  logic                     clr_flags,
  output logic [WIDTH-1:0]         out_l,
  output logic [WIDTH-1:0]         out_r,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               underflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LEVEL_HALF = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [AW:0]        level_r;
  logic [AW:0]        level_nxt_s;
  logic               in_ready_r;
  state_t             state_r;
  state_t             state_nxt_s;
  logic [2*WIDTH-1:0] last_r;
  logic               stg1_valid_r;
  logic [WIDTH-1:0]   out_l_r;
  logic [WIDTH-1:0]   out_r_r;
  logic               out_valid_r;
  logic               overflow_r;
  logic [7:0]         uf_cnt_r;

  logic               full_s;
  logic               empty_s;
  logic               wr_fire_s;
  logic               drop_s;
  logic               pop_s;
  logic               uf_event_s;

  logic signed [WIDTH-1:0] ch_l_s;
  logic signed [WIDTH-1:0] ch_r_s;
  logic signed [WIDTH:0]   sum_s;
  logic signed [WIDTH-1:0] proc_l_s;
  logic signed [WIDTH-1:0] proc_r_s;

  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  // in_ready_r mirrors !full_s; using the registered copy means a write
  // while full is dropped even if a pop frees a slot in the same cycle.
  assign wr_fire_s  = in_valid && in_ready_r;
  assign drop_s     = in_valid && !in_ready_r;

  // Entry count after this cycle's accepted write and/or pop
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_fire_s, pop_s})
      2'b10:   level_nxt_s = level_r + LEVEL_ONE;
      2'b01:   level_nxt_s = level_r - LEVEL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Playback state: prime to half full, then serve requests until underflow
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    uf_event_s  = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (level_r >= LEVEL_HALF) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_RUN: begin
        if (out_req && !empty_s) begin
          pop_s = 1'b1;
        end else if (out_req) begin
          uf_event_s  = 1'b1;
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
      end
    endcase
  end

  // Stage-2 sample processing: optional mono mix, then arithmetic attenuation
  always_comb begin
    sum_s = $signed({last_r[2*WIDTH-1], last_r[2*WIDTH-1:WIDTH]}) +
            $signed({last_r[WIDTH-1], last_r[WIDTH-1:0]});
    if (mono) begin
      ch_l_s = sum_s[WIDTH:1];
      ch_r_s = sum_s[WIDTH:1];
    end else begin
      ch_l_s = $signed(last_r[2*WIDTH-1:WIDTH]);
      ch_r_s = $signed(last_r[WIDTH-1:0]);
    end
    proc_l_s = ch_l_s >>> vol_shift;
    proc_r_s = ch_r_s >>> vol_shift;
  end

  // Sample storage; contents are only meaningful behind the pointers
  always_ff @(posedge clk_50MHz) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {in_l, in_r};
    end
  end

  // Pointers, level, ready flag and FSM state
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      in_ready_r <= 1'b1;
      state_r    <= ST_FILL;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + LEVEL_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + LEVEL_ONE;
      end
      level_r    <= level_nxt_s;
      in_ready_r <= (level_nxt_s != LEVEL_FULL);
      state_r    <= state_nxt_s;
    end
  end

  // Stage 1: latch the popped frame, or keep the last one for concealment
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      last_r       <= '0;
      stg1_valid_r <= 1'b0;
    end else begin
      if (pop_s) begin
        last_r <= mem_r[rd_ptr_r[AW-1:0]];
      end
      stg1_valid_r <= out_req;
    end
  end

  // Stage 2: registered DAC outputs, held between pulses
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      out_l_r     <= '0;
      out_r_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (stg1_valid_r) begin
        out_l_r <= proc_l_s;
        out_r_r <= proc_r_s;
      end
      out_valid_r <= stg1_valid_r;
    end
  end

  // Sticky status; a same-cycle event beats the clear request
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
      uf_cnt_r   <= 8'd0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_flags) begin
        overflow_r <= 1'b0;
      end
      if (uf_event_s && clr_flags) begin
        uf_cnt_r <= 8'd1;
      end else if (uf_event_s) begin
        if (uf_cnt_r != 8'd255) begin
          uf_cnt_r <= uf_cnt_r + 8'd1;
        end
      end else if (clr_flags) begin
        uf_cnt_r <= 8'd0;
      end
    end
  end

  assign in_ready      = in_ready_r;
  assign out_l         = out_l_r;
  assign out_r         = out_r_r;
  assign out_valid     = out_valid_r;
  assign level         = level_r;
  assign overflow      = overflow_r;
  assign underflow_cnt = uf_cnt_r;

endmodule
